// File: rtl/router_output_allocator.sv
// Wormhole output-port allocator: round-robin arbitration among inputs in IDLE,
// the winning packet holds the port until its tail flit, and a credit counter gates every grant.
module router_output_allocator #(
  parameter int NUM_INPUTS = 5,
  parameter int CREDITS    = 4,
  localparam int IDX_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int CNT_W     = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [NUM_INPUTS-1:0] tail,
  input  logic                  credit_in,
  output logic [NUM_INPUTS-1:0] grant,
  output logic                  valid_out,
  output logic                  locked,
  output logic [CNT_W-1:0]      credit_count,
  output logic                  credit_overflow
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [IDX_W-1:0]        owner;
  logic [IDX_W-1:0]        owner_next;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        rr_next;
  logic [IDX_W-1:0]        cand;
  logic [IDX_W-1:0]        winner;
  logic [IDX_W-1:0]        sel;
  logic                    found;
  logic                    credit_ok;
  logic                    transfer;
  logic [NUM_INPUTS-1:0]   grant_c;

  // Round-robin search starts one past the last tail winner and wraps.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_INPUTS);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    grant_c   = '0;
    credit_ok = (credit_count != '0);
    sel       = (state == LOCKED) ? owner : winner;
    if (!rst && credit_ok) begin
      case (state)
        IDLE:    if (found)      grant_c[winner] = 1'b1;
        LOCKED:  if (req[owner]) grant_c[owner]  = 1'b1;
        default: grant_c = '0;
      endcase
    end
    transfer = |grant_c;
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    rr_next    = rr_ptr;
    if (transfer) begin
      case (state)
        IDLE: begin
          if (tail[sel]) begin
            rr_next = sel;
          end else begin
            state_next = LOCKED;
            owner_next = sel;
          end
        end
        LOCKED: begin
          if (tail[sel]) begin
            state_next = IDLE;
            rr_next    = sel;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= IDX_W'(NUM_INPUTS - 1);
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      rr_ptr <= rr_next;
    end
  end

  // A simultaneous transfer and returned credit cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_count    <= CNT_W'(CREDITS);
      credit_overflow <= 1'b0;
    end else begin
      case ({transfer, credit_in})
        2'b10: credit_count <= credit_count - 1'b1;
        2'b01: begin
          if (credit_count == CNT_W'(CREDITS)) credit_overflow <= 1'b1;
          else                                 credit_count    <= credit_count + 1'b1;
        end
        default: credit_count <= credit_count;
      endcase
    end
  end

  assign grant     = grant_c;
  assign valid_out = transfer;
  assign locked    = (state == LOCKED);

endmodule

// File: doc/router_output_allocator.md
ROUTER_OUTPUT_ALLOCATOR -- requirements
Module: router_output_allocator

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 5, number of router input ports (N/S/W/E/Local) competing for this output port.
REQ-002 SHALL have parameter CREDITS, default 4, downstream input-buffer depth in flits.
REQ-003 SHALL have port clk  input  1  clock; one clock domain, all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req  input  NUM_INPUTS  input i holds a valid flit whose lookahead routing selects this output.
REQ-006 SHALL have port tail  input  NUM_INPUTS  flit at input i is a tail flit; a single-flit packet has head and tail set together; sampled only with req.
REQ-007 SHALL have port credit_in  input  1  one-cycle pulse: downstream freed one buffer slot.
REQ-008 SHALL have port grant  output  NUM_INPUTS  one-hot or zero; grant[i]=1 means the input-i flit transfers this cycle.
REQ-009 SHALL have port valid_out  output  1  OR of grant; a flit is forwarded this cycle.
REQ-010 SHALL have port locked  output  1  a wormhole packet currently owns the port.
REQ-011 SHALL have port credit_count  output  $clog2(CREDITS+1)  available downstream credits.
REQ-012 SHALL have port credit_overflow  output  1  sticky error: credit_in received with credit_count==CREDITS.

Function
REQ-013 SHALL implement two states: IDLE (no owner) and LOCKED (owner register holds an input index).
REQ-014 grant SHALL be combinational from current state, req and credit_count; a transfer occurs in the same cycle grant is high.
REQ-015 No grant SHALL be issued when credit_count==0, in either state.
REQ-016 IDLE: winner is the first i with req[i]=1, searching from (rr_ptr+1) mod NUM_INPUTS upward with wrap-around; grant[winner]=1 if credits>0.
REQ-017 IDLE transfer with tail[winner]=0: next state LOCKED, owner<=winner.
REQ-018 IDLE transfer with tail[winner]=1 (single-flit packet): stay IDLE, rr_ptr<=winner.
REQ-019 LOCKED: grant[owner]=req[owner] and credits>0; requests from other inputs SHALL be ignored.
REQ-020 LOCKED transfer with tail[owner]=1: next state IDLE, rr_ptr<=owner; rearbitration occurs no earlier than the following cycle.
REQ-021 LOCKED with req[owner]=0 (bubble) SHALL hold the lock; there is no timeout.
REQ-022 rr_ptr SHALL update only on tail transfer; it SHALL NOT change for body flits or cycles without a grant.
REQ-023 credit_count SHALL be decremented by 1 on transfer and incremented by 1 on credit_in; on a simultaneous transfer and credit_in it SHALL remain unchanged.
REQ-024 credit_in with credit_count==CREDITS and no transfer SHALL leave the count at CREDITS and set credit_overflow.
REQ-025 locked SHALL equal (state==LOCKED), registered.
REQ-026 Width of every index register SHALL be $clog2(NUM_INPUTS); values greater than or equal to NUM_INPUTS SHALL never be produced.

Reset
REQ-027 On rst=1 at posedge: state=IDLE, rr_ptr=NUM_INPUTS-1, so input 0 has the highest priority first; credit_count=CREDITS; credit_overflow=0.
REQ-028 While rst=1: grant=0 and valid_out=0, regardless of req.
REQ-029 A reset asserted mid-packet SHALL drop the lock and owner immediately; no tail is required.

Verification
REQ-030 Reset, then req=5'b10110, tail=all 1 for 3 cycles with credit_in tied to transfers -> grants 00010, 00100, 10000; rr_ptr then 4.
REQ-031 Input 1 sends head (tail=0), then inputs 0 and 3 also request -> grant stays 00010 for body flits; after input-1 tail, next grant goes to 00001 or 01000 per rr_ptr=1, i.e. 01000.
REQ-032 CREDITS=4, no credit_in, input 2 streams 6 flits -> 4 grants, credit_count=0, then grant=0; one credit_in pulse -> exactly one more grant.
REQ-033 credit_count=2, transfer and credit_in in the same cycle -> credit_count stays 2; credit_in at 4 with no transfer -> stays 4, credit_overflow=1 until reset.
REQ-034 LOCKED on input 4 with a req[4] bubble for 3 cycles while input 0 requests -> grant=0 throughout, locked=1; rst pulse -> locked=0, next cycle grant=00001.
